nbit_seq_divider: RTL and testbench
===================================

Name: nbit_seq_divider

Overview:
Sequential restoring divider; the inverse operation of the team's combinational N-bit multiplier.
- Takes a 2N-bit dividend (for example, a product p) and an N-bit divisor.
- Returns a 2N-bit quotient and an N-bit remainder over 2N clock cycles.
- Uses a start/busy/done handshake.
- Sits beside the multiplier so that results can be round-trip checked: dividend = quotient*divisor + remainder.

Parameters:
- N, 4, divisor and remainder width; the dividend and quotient are 2N bits wide.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a division; sampled only when the block can accept (state IDLE or DONE)
- dividend  input  2N  numerator, captured at the accepting edge
- divisor  input  N  denominator, captured at the accepting edge
- busy  output  1  high while in RUN
- done  output  1  single-cycle pulse; results are valid from this cycle
- quotient  output  2N  registered result, held until the next completion
- remainder  output  N  registered result, held until the next completion
- div_by_zero  output  1  set with done when the captured divisor was 0; held with the results

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (rst_n).
- While rst_n=0, all of the following are 0: state=IDLE, busy, done, quotient, remainder, div_by_zero.
- Reset asserted mid-RUN aborts the operation. No done pulse is produced and partial results are discarded.
- States:
  - IDLE: start=1 with divisor!=0 goes to RUN. start=1 with divisor=0 goes to DONE.
  - RUN: iteration counter counts 2N-1 down to 0. At count 0 the next state is DONE.
  - DONE: start=1 accepts exactly as in IDLE (back-to-back operation). Otherwise go to IDLE.
- Accepting edge (edge 0):
  - Capture the dividend into a shift register A (2N bits).
  - Capture the divisor into B (N bits).
  - Clear the partial remainder R (N+1 bits).
  - Load counter = 2N-1.
- Each RUN edge, restoring step:
  - T = {R[N-1:0], A[2N-1]} - {1'b0, B}.
  - If T is non-negative: R = T and shift 1 into A's LSB.
  - Otherwise: R = {R[N-1:0], A[2N-1]} and shift 0 into A's LSB.
  - A shifts left by 1 each step.
- Latency (divisor != 0): RUN occupies edges 1..2N. busy=1 in the cycles after edges 0..2N-1.
  - At edge 2N: quotient<=A (after the final shift), remainder<=R[N-1:0], div_by_zero<=0, done<=1.
  - done is therefore high in the cycle after edge 2N, which is 2N+1 edges after acceptance (9 edges for N=4).
- Divide by zero: the accepting edge goes directly to DONE and loads quotient=all ones, remainder=0, div_by_zero=1, done=1. Latency is 1 edge, and busy never asserts.
- start while busy: ignored, with no effect on the operation in progress. dividend and divisor are not re-sampled during RUN.
- Outputs change only at a completion edge or at reset. An accepting edge does not clear the previous results.
- done is high for exactly one cycle per accepted operation.
- Widths: the quotient needs a 2N-bit register because dividend/1 can reach 2^(2N)-1. The remainder is always less than the divisor, so N bits suffice. All arithmetic is unsigned.

Decomposition:
Shared package nbit_arith_pkg contains:
- the state enum (IDLE, RUN, DONE)
- DIV_N default
- a localparam for the counter width, $clog2(2N)

One sub-module: nbit_div_step. It is a combinational single restoring step with inputs R, next dividend bit and B, and outputs the new R and the quotient bit. The top level keeps the FSM, counter and registers.

Test Plan:
- N=4. dividend=8'd143, divisor=4'd11, start pulsed for 1 cycle -> busy for 8 cycles, then done in the 9th cycle after acceptance; quotient=8'd13, remainder=4'd0, div_by_zero=0.
- dividend=8'd100, divisor=4'd7 -> quotient=8'd14, remainder=4'd2. dividend=8'd255, divisor=4'd1 -> quotient=8'd255, remainder=4'd0.
- dividend=8'd50, divisor=4'd0 -> done 1 edge after acceptance, busy stays 0, quotient=8'hFF, remainder=0, div_by_zero=1. A following 8'd50/4'd5 gives quotient=10, remainder=0, div_by_zero=0.
- Start 8'd200/4'd9. Re-pulse start with 8'd1/4'd1 at cycle 3 of RUN -> ignored; the result is quotient=22, remainder=2. Then assert start again in the done cycle with 8'd64/4'd8 -> accepted immediately; quotient=8, remainder=0 after 9 more edges.
- Start 8'd77/4'd3, then drop rst_n at cycle 4 of RUN -> all outputs are 0 asynchronously and no done pulse appears. After release, 8'd77/4'd3 gives quotient=25, remainder=2.
- Exhaustive: all 256 dividends x divisors 1..15 -> at each done, check quotient*divisor+remainder==dividend and remainder<divisor. Stop on the first mismatch and print the operands.

Source files
------------

// File: rtl/nbit_arith_pkg.sv
// Shared types and sizing helpers for the sequential N-bit arithmetic blocks.
package nbit_arith_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} DivState;

  localparam int DIV_N = 4;

  // Iteration counter must hold 2N-1 for an N-bit divisor / 2N-bit dividend.
  function automatic int cntWidth(input int n);
    return $clog2(2 * n);
  endfunction

  localparam int DIV_CNT_W = cntWidth(DIV_N);

endpackage

// File: rtl/nbit_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module nbit_div_step import nbit_arith_pkg::*; #(
  parameter int N = DIV_N
) (
  input  logic [N-1:0] rIn,
  input  logic         dividendBit,
  input  logic [N-1:0] b,
  output logic [N-1:0] rOut,
  output logic         qBit
);

  logic [N:0] shifted;

  // The partial remainder stays below the divisor, so N bits always hold the kept value.
  always_comb begin
    shifted = {rIn, dividendBit};
    qBit    = (shifted >= {1'b0, b});
    rOut    = qBit ? N'(shifted - {1'b0, b}) : shifted[N-1:0];
  end

endmodule

// File: rtl/nbit_seq_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor over 2N cycles, start/busy/done handshake.
module nbit_seq_divider import nbit_arith_pkg::*; #(
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int CNT_W = cntWidth(N);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(2 * N - 1);

  DivState          state;
  DivState          nextState;
  logic [CNT_W-1:0] count;
  logic [2*N-1:0]   aReg;
  logic [N-1:0]     bReg;
  logic [N-1:0]     rReg;
  logic [N-1:0]     rNext;
  logic             qBit;
  logic             accept;
  logic             divZero;
  logic             lastStep;

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign divZero  = (divisor == '0);
  assign lastStep = (state == RUN) && (count == '0);

  nbit_div_step #(.N(N)) stepUnit (
    .rIn         (rReg),
    .dividendBit (aReg[2*N-1]),
    .b           (bReg),
    .rOut        (rNext),
    .qBit        (qBit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE, DONE: begin
        if (start) nextState = divZero ? DONE : RUN;
        else       nextState = IDLE;
      end
      RUN:     nextState = (count == '0) ? DONE : RUN;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Working registers; the quotient bits accumulate in aReg as the dividend shifts out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      aReg  <= '0;
      bReg  <= '0;
      rReg  <= '0;
    end else if (accept) begin
      count <= CNT_LOAD;
      aReg  <= dividend;
      bReg  <= divisor;
      rReg  <= '0;
    end else if (state == RUN) begin
      count <= count - CNT_W'(1);
      aReg  <= {aReg[2*N-2:0], qBit};
      rReg  <= rNext;
    end
  end

  // Results only move at a completion, so a new acceptance leaves the previous answer visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept && divZero) begin
      quotient    <= '1;
      remainder   <= '0;
      div_by_zero <= 1'b1;
    end else if (lastStep) begin
      quotient    <= {aReg[2*N-2:0], qBit};
      remainder   <= rNext;
      div_by_zero <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nbit_seq_divider.sv
// Directed self-checking bench for nbit_seq_divider with N=4.
module tb_nbit_seq_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int total;
  int bad;

  nbit_seq_divider #(.N(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands with start for one edge; returns 1ns after the accepting edge.
  task automatic applyStimulus(input logic [7:0] dd, input logic [3:0] dv);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Latency counts edges from acceptance (accepting edge = 1) until done is seen.
  task automatic waitDone(output int lat, output bit timedOut);
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    timedOut = (done !== 1'b1);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got busy=%b done=%b q=%0d r=%0d dz=%b want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int lat;
    int busyCnt;
    applyStimulus(8'd143, 4'd11);
    lat     = 1;
    busyCnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busyCnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    total++;
    if (lat != 9) begin
      bad++;
      $display("[TB] FAIL basic_latency got=%0d want=9", lat);
    end
    total++;
    if (busyCnt != 8) begin
      bad++;
      $display("[TB] FAIL basic_busy_cycles got=%0d want=8", busyCnt);
    end
    total++;
    if ({busy, quotient, remainder, div_by_zero} !== {1'b0, 8'd13, 4'd0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL basic_result got busy=%b q=%0d r=%0d dz=%b want busy=0 q=13 r=0 dz=0",
               busy, quotient, remainder, div_by_zero);
    end
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0 || quotient !== 8'd13) begin
      bad++;
      $display("[TB] FAIL basic_pulse_hold got done=%b q=%0d want done=0 q=13", done, quotient);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] dds [2] = '{8'd100, 8'd255};
    logic [3:0] dvs [2] = '{4'd7, 4'd1};
    logic [7:0] qs  [2] = '{8'd14, 8'd255};
    logic [3:0] rs  [2] = '{4'd2, 4'd0};
    int  lat;
    bit  to;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(dds[i], dvs[i]);
      waitDone(lat, to);
      total++;
      if (to || lat != 9 || quotient !== qs[i] || remainder !== rs[i] || div_by_zero !== 1'b0) begin
        bad++;
        $display("[TB] FAIL vector_%0d got lat=%0d q=%0d r=%0d dz=%b want lat=9 q=%0d r=%0d dz=0",
                 i, lat, quotient, remainder, div_by_zero, qs[i], rs[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_div_zero();
    int lat;
    bit to;
    applyStimulus(8'd50, 4'd0);
    waitDone(lat, to);
    total++;
    if (to || lat != 1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL dz_latency got lat=%0d busy=%b want lat=1 busy=0", lat, busy);
    end
    total++;
    if (quotient !== 8'hFF || remainder !== 4'd0 || div_by_zero !== 1'b1) begin
      bad++;
      $display("[TB] FAIL dz_result got q=%h r=%0d dz=%b want q=ff r=0 dz=1",
               quotient, remainder, div_by_zero);
    end
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b1) begin
      bad++;
      $display("[TB] FAIL dz_after got done=%b busy=%b dz=%b want done=0 busy=0 dz=1",
               done, busy, div_by_zero);
    end
    applyStimulus(8'd50, 4'd5);
    waitDone(lat, to);
    total++;
    if (to || quotient !== 8'd10 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
      bad++;
      $display("[TB] FAIL dz_recover got q=%0d r=%0d dz=%b want q=10 r=0 dz=0",
               quotient, remainder, div_by_zero);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    bit to;
    applyStimulus(8'd200, 4'd9);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    dividend = 8'd1;
    divisor  = 4'd1;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 4;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    total++;
    if (lat != 9 || quotient !== 8'd22 || remainder !== 4'd2) begin
      bad++;
      $display("[TB] FAIL ignore_start got lat=%0d q=%0d r=%0d want lat=9 q=22 r=2",
               lat, quotient, remainder);
    end
    applyStimulus(8'd64, 4'd8);
    total++;
    if (busy !== 1'b1 || quotient !== 8'd22) begin
      bad++;
      $display("[TB] FAIL b2b_accept got busy=%b q=%0d want busy=1 q=22", busy, quotient);
    end
    waitDone(lat, to);
    total++;
    if (to || lat != 9 || quotient !== 8'd8 || remainder !== 4'd0) begin
      bad++;
      $display("[TB] FAIL b2b_result got lat=%0d q=%0d r=%0d want lat=9 q=8 r=0",
               lat, quotient, remainder);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bit to;
    bit sawDone;
    applyStimulus(8'd77, 4'd3);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
      bad++;
      $display("[TB] FAIL midrun_reset got busy=%b done=%b q=%0d r=%0d dz=%b want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    sawDone = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) sawDone = 1'b1;
    end
    total++;
    if (sawDone) begin
      bad++;
      $display("[TB] FAIL midrun_no_done got activity=1 want activity=0");
    end
    applyStimulus(8'd77, 4'd3);
    waitDone(lat, to);
    total++;
    if (to || lat != 9 || quotient !== 8'd25 || remainder !== 4'd2) begin
      bad++;
      $display("[TB] FAIL midrun_recover got lat=%0d q=%0d r=%0d want lat=9 q=25 r=2",
               lat, quotient, remainder);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_exhaustive();
    int lat;
    bit to;
    bit stop;
    stop = 1'b0;
    for (int dd = 0; dd < 256 && !stop; dd++) begin
      for (int dv = 1; dv < 16 && !stop; dv++) begin
        applyStimulus(8'(dd), 4'(dv));
        waitDone(lat, to);
        total++;
        if (to || (int'(quotient) * dv + int'(remainder)) != dd || int'(remainder) >= dv) begin
          bad++;
          stop = 1'b1;
          $display("[TB] FAIL exhaustive dividend=%0d divisor=%0d got q=%0d r=%0d timeout=%b",
                   dd, dv, quotient, remainder, to);
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_run();
    test_exhaustive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
